// File: rtl/shift_add_mac.sv
// shift_add_mac: unsigned WIDTH x WIDTH shift-and-add multiplier feeding a wrapping accumulator.
// One multiplier bit is consumed per cycle; start/busy/done handshake toward the controller.
module shift_add_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear_acc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [PW-1:0]        mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [PW-1:0]        product_r;
  logic [CNT_W-1:0]     count_r;
  logic                 clr_pending_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic                 overflow_r;
  logic                 busy_r;
  logic                 done_r;
  logic [PW-1:0]        partial_s;
  logic [ACC_WIDTH:0]   acc_sum_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign acc_out  = acc_r;
  assign overflow = overflow_r;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; MULT always runs the full WIDTH iterations.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = MULT;
        end else begin
          state_next_s = IDLE;
        end
      end
      MULT: begin
        if (count_r == LAST_CNT) begin
          state_next_s = ACC;
        end else begin
          state_next_s = MULT;
        end
      end
      ACC:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Partial-product mux and accumulator adder with carry-out.
  always_comb begin
    partial_s = {PW{1'b0}};
    if (mplier_r[0]) begin
      partial_s = mcand_r;
    end else begin
      partial_s = {PW{1'b0}};
    end
    acc_sum_s = {1'b0, acc_r} + {1'b0, ACC_WIDTH'(product_r)};
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r       <= {PW{1'b0}};
      mplier_r      <= {WIDTH{1'b0}};
      product_r     <= {PW{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      clr_pending_r <= 1'b0;
      acc_r         <= {ACC_WIDTH{1'b0}};
      overflow_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r       <= PW'(a);
            mplier_r      <= b;
            product_r     <= {PW{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            clr_pending_r <= clear_acc;
            busy_r        <= 1'b1;
          end else if (clear_acc) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            overflow_r <= 1'b0;
          end
        end
        MULT: begin
          product_r <= product_r + partial_s;
          mcand_r   <= {mcand_r[PW-2:0], 1'b0};
          mplier_r  <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r   <= count_r + CNT_W'(1'b1);
        end
        ACC: begin
          // A pending clear replaces the accumulator instead of adding into it.
          if (clr_pending_r) begin
            acc_r      <= ACC_WIDTH'(product_r);
            overflow_r <= 1'b0;
          end else begin
            acc_r      <= acc_sum_s[ACC_WIDTH-1:0];
            overflow_r <= overflow_r | acc_sum_s[ACC_WIDTH];
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mac.sv
// Scoreboard bench for shift_add_mac: a cycle-level arithmetic model queues expected done
// cycles and tracks the visible accumulator; a negedge monitor compares every cycle.
module tb_shift_add_mac;

  localparam int     WIDTH     = 8;
  localparam int     ACC_WIDTH = 20;
  localparam longint ACC_MOD   = 64'd1 << ACC_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 clear_acc = 1'b0;
  logic [WIDTH-1:0]     a = '0;
  logic [WIDTH-1:0]     b = '0;
  logic                 busy;
  logic                 done;
  logic [ACC_WIDTH-1:0] acc_out;
  logic                 overflow;

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int     cyc       = 0;
  int     acc_cyc   = 0;
  bit     active    = 1'b0;
  longint shown_acc = 0;
  bit     shown_ovf = 1'b0;
  longint pend_acc  = 0;
  bit     pend_ovf  = 1'b0;
  int     q[$];

  shift_add_mac #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear_acc (clear_acc),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .overflow  (overflow)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one operation from IDLE or the done cycle; returns in the done cycle.
  task automatic op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input bit clr);
    start = 1'b1; clear_acc = clr; a = aa; b = bb;
    step();
    start = 1'b0; clear_acc = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom);
    repeat (WIDTH + 1) step();
  endtask

  // Behavioural model: whole products via multiplication, visible at the done cycle.
  initial begin
    longint prod;
    longint sum;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        active = 1'b0; shown_acc = 0; shown_ovf = 1'b0; q.delete();
      end else begin
        cyc++;
        if (!active) begin
          if (start) begin
            prod = longint'(a) * longint'(b);
            if (clear_acc) begin
              pend_acc = prod; pend_ovf = 1'b0;
            end else begin
              sum = shown_acc + prod;
              pend_ovf = shown_ovf || (sum >= ACC_MOD);
              pend_acc = sum % ACC_MOD;
            end
            active = 1'b1; acc_cyc = cyc;
            q.push_back(cyc + WIDTH + 1);
          end else if (clear_acc) begin
            shown_acc = 0; shown_ovf = 1'b0;
          end
        end else if (cyc == acc_cyc + WIDTH + 1) begin
          shown_acc = pend_acc; shown_ovf = pend_ovf; active = 1'b0;
        end
      end
    end
  end

  // Monitor: compare outputs each cycle; pop the scoreboard when done shows.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("busy", busy, active);
        check("acc_out", acc_out, 32'(shown_acc));
        check("overflow", overflow, shown_ovf);
        if (done) begin
          if (q.size() == 0) begin
            check("done_unexpected", done, 1'b0);
          end else begin
            check("done_cycle", cyc, q.pop_front());
          end
        end else if (q.size() > 0 && q[0] <= cyc) begin
          check("done_missing", done, 1'b1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    // 1: reset, then idle with no done
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("reset_acc", acc_out, 0);
    check("reset_ovf", overflow, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (20) step();

    // 2 and 3: cleared 3*5, then 255*255 issued in the done cycle
    op(8'd3, 8'd5, 1'b1);
    check("t2_done", done, 1);
    check("t2_acc", acc_out, 15);
    check("t2_ovf", overflow, 0);
    op(8'd255, 8'd255, 1'b0);
    check("t3_done", done, 1);
    check("t3_acc", acc_out, 65040);

    // 4: clear, 17 ops of 255*255, then 1*1, then idle clear
    clear_acc = 1'b1; step(); clear_acc = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      op(8'd255, 8'd255, 1'b0);
      if (i == 16) begin
        check("t4_acc16", acc_out, 1040400);
        check("t4_ovf16", overflow, 0);
      end
    end
    check("t4_acc17", acc_out, 56849);
    check("t4_ovf17", overflow, 1);
    op(8'd1, 8'd1, 1'b0);
    check("t4_acc18", acc_out, 56850);
    check("t4_ovf18", overflow, 1);
    step();
    clear_acc = 1'b1; step(); clear_acc = 1'b0;
    #1;
    check("t4_clr_acc", acc_out, 0);
    check("t4_clr_ovf", overflow, 0);

    // 5: product zero with start/a/b/clear_acc toggling while busy
    start = 1'b1; a = 8'd200; b = 8'd0; step();
    repeat (WIDTH + 1) begin
      start = 1'($urandom); clear_acc = 1'($urandom);
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      step();
    end
    start = 1'b0; clear_acc = 1'b0;
    check("t5_done", done, 1);
    check("t5_acc", acc_out, 0);
    step();
    check("t5_busy_after", busy, 0);

    // 6: asynchronous reset mid-multiply, then fresh accumulation
    op(8'd3, 8'd5, 1'b1);
    check("t6_prior", acc_out, 15);
    start = 1'b1; clear_acc = 1'b0; a = 8'd10; b = 8'd10; step();
    start = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    check("t6_async_acc", acc_out, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_done", done, 0);
    step(); step();
    reset = 1'b0;
    op(8'd10, 8'd10, 1'b0);
    check("t6_acc", acc_out, 100);

    // random operations with idle gaps and idle clears
    for (int n = 0; n < 40; n++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        clear_acc = ($urandom_range(0, 5) == 0);
        step();
        clear_acc = 1'b0;
      end
      op(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 7) == 0);
    end
    repeat (3) step();
    check("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
